// File: rtl/uart_rx_frame_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_frame_if
//  Brief    : Serial line input and received-byte result bundle for uart_rx_frame.
//  Revision : 1.0
// ============================================================================
interface uart_rx_frame_if;
  logic       Serial_ip;
  logic [7:0] Dataout;
  logic       Valid;
  logic       Parity_err;
  logic       Frame_err;
  logic       Busy;

  modport master (
    output Serial_ip,
    input  Dataout, Valid, Parity_err, Frame_err, Busy
  );

  modport slave (
    input  Serial_ip,
    output Dataout, Valid, Parity_err, Frame_err, Busy
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx_frame.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_frame
//  Brief    : Oversampling UART receiver: start, 8 data LSB-first, even parity,
//             STOP_BITS stop bits; one-cycle Valid with parity/frame status.
//  Revision : 1.0
// ============================================================================
module uart_rx_frame #(
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 2
) (
  input  wire logic      Clk,
  input  wire logic      Rst,
  uart_rx_frame_if.slave bus
);

  localparam int              CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [1:0]       STOP_LAST = 2'(STOP_BITS - 1);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_START   = 3'd1;
  localparam logic [2:0] ST_DATA    = 3'd2;
  localparam logic [2:0] ST_PARITY  = 3'd3;
  localparam logic [2:0] ST_STOP    = 3'd4;
  localparam logic [2:0] ST_WAIT_HI = 3'd5;

  logic             sync1_q, sync2_q, rx_prev_q;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [1:0]       stop_cnt_q, stop_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             p_rx_q, p_rx_d;
  logic             ferr_q, ferr_d;
  logic [7:0]       dataout_q, dataout_d;
  logic             valid_q, valid_d;
  logic             perr_q, perr_d;
  logic             frame_err_q, frame_err_d;
  logic             busy;

  logic w_rx_s;
  logic w_fall;
  logic w_done;

  assign w_rx_s = sync2_q;
  assign w_fall = rx_prev_q & ~w_rx_s;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      rx_prev_q   <= 1'b1;
      state_q     <= ST_IDLE;
      clk_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      stop_cnt_q  <= '0;
      shift_q     <= '0;
      p_rx_q      <= 1'b0;
      ferr_q      <= 1'b0;
      dataout_q   <= '0;
      valid_q     <= 1'b0;
      perr_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sync1_q     <= bus.Serial_ip;
      sync2_q     <= sync1_q;
      rx_prev_q   <= w_rx_s;
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      stop_cnt_q  <= stop_cnt_d;
      shift_q     <= shift_d;
      p_rx_q      <= p_rx_d;
      ferr_q      <= ferr_d;
      dataout_q   <= dataout_d;
      valid_q     <= valid_d;
      perr_q      <= perr_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clk_cnt_d  = clk_cnt_q + 1'b1;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    shift_d    = shift_q;
    p_rx_d     = p_rx_q;
    ferr_d     = ferr_q;
    case (state_q)
      ST_IDLE: begin
        clk_cnt_d = '0;
        if (w_fall) state_d = ST_START;
      end
      ST_START: begin
        if (clk_cnt_q == CNT_HALF) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = w_rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (clk_cnt_q == CNT_LAST) begin
          clk_cnt_d = '0;
          shift_d   = {w_rx_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (clk_cnt_q == CNT_LAST) begin
          clk_cnt_d  = '0;
          p_rx_d     = w_rx_s;
          stop_cnt_d = '0;
          ferr_d     = 1'b0;
          state_d    = ST_STOP;
        end
      end
      ST_STOP: begin
        if (clk_cnt_q == CNT_LAST) begin
          clk_cnt_d = '0;
          if (!w_rx_s) ferr_d = 1'b1;
          // A low final stop means break: hold off new frames until the line recovers
          if (stop_cnt_q == STOP_LAST) state_d = w_rx_s ? ST_IDLE : ST_WAIT_HI;
          else                         stop_cnt_d = stop_cnt_q + 2'd1;
        end
      end
      ST_WAIT_HI: begin
        clk_cnt_d = '0;
        if (w_rx_s) state_d = ST_IDLE;
      end
      default: begin
        clk_cnt_d = '0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  assign w_done = (state_q == ST_STOP) && (clk_cnt_q == CNT_LAST) &&
                  (stop_cnt_q == STOP_LAST);

  always_comb begin
    valid_d     = w_done;
    dataout_d   = dataout_q;
    perr_d      = perr_q;
    frame_err_d = frame_err_q;
    busy        = (state_q != ST_IDLE);
    if (w_done) begin
      dataout_d   = shift_q;
      perr_d      = p_rx_q ^ (^shift_q);
      frame_err_d = ferr_q | ~w_rx_s;
    end
  end

  assign bus.Dataout    = dataout_q;
  assign bus.Valid      = valid_q;
  assign bus.Parity_err = perr_q;
  assign bus.Frame_err  = frame_err_q;
  assign bus.Busy       = busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_frame.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_frame
//  Brief    : Directed self-checking bench for uart_rx_frame (16 clk/bit, 2 stops).
//  Revision : 1.0
// ============================================================================
module tb_uart_rx_frame;
  localparam int CPB = 16;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [9:0] vq[$];   // {Frame_err, Parity_err, Dataout} per Valid

  uart_rx_frame_if bus();

  uart_rx_frame #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk)
    if (bus.Valid === 1'b1) vq.push_back({bus.Frame_err, bus.Parity_err, bus.Dataout});

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    bus.Serial_ip = b;
    tick(CPB);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic flip_par, input logic stop2);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit((^d) ^ flip_par);
    drive_bit(1'b1);
    drive_bit(stop2);
  endtask

  task automatic test_reset();
    bus.Serial_ip = 1'b1;
    Rst = 1'b1;
    tick(3);
    n_cmp++; if (bus.Dataout !== 8'h00) begin n_bad++; $display("FAIL rst_dataout got %h want 00", bus.Dataout); end
    n_cmp++; if (bus.Valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b want 0", bus.Valid); end
    n_cmp++; if (bus.Parity_err !== 1'b0) begin n_bad++; $display("FAIL rst_perr got %b want 0", bus.Parity_err); end
    n_cmp++; if (bus.Frame_err !== 1'b0) begin n_bad++; $display("FAIL rst_ferr got %b want 0", bus.Frame_err); end
    Rst = 1'b0;
    tick(4);
    n_cmp++; if (bus.Busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", bus.Busy); end
  endtask

  task automatic test_good_frame();
    vq.delete();
    send_frame(8'hA5, 1'b0, 1'b1);
    tick(4);
    n_cmp++;
    if (vq.size() !== 1) begin n_bad++; $display("FAIL good_count got %0d want 1", vq.size()); end
    else begin
      n_cmp++;
      if (vq[0] !== 10'h0A5) begin n_bad++; $display("FAIL good_frame got %h want 0a5", vq[0]); end
    end
    n_cmp++; if (bus.Busy !== 1'b0) begin n_bad++; $display("FAIL good_busy got %b want 0", bus.Busy); end
  endtask

  task automatic test_parity_err();
    vq.delete();
    send_frame(8'h3C, 1'b1, 1'b1);
    tick(4);
    n_cmp++;
    if (vq.size() !== 1) begin n_bad++; $display("FAIL par_count got %0d want 1", vq.size()); end
    else begin
      n_cmp++;
      if (vq[0] !== 10'h13C) begin n_bad++; $display("FAIL par_frame got %h want 13c", vq[0]); end
    end
  endtask

  task automatic test_glitch();
    vq.delete();
    bus.Serial_ip = 1'b0;
    tick(4);
    n_cmp++; if (bus.Busy !== 1'b1) begin n_bad++; $display("FAIL glitch_busy_hi got %b want 1", bus.Busy); end
    bus.Serial_ip = 1'b1;
    tick(8);
    n_cmp++; if (bus.Busy !== 1'b0) begin n_bad++; $display("FAIL glitch_busy_lo got %b want 0", bus.Busy); end
    tick(200);
    n_cmp++; if (vq.size() !== 0) begin n_bad++; $display("FAIL glitch_valid got %0d want 0", vq.size()); end
    n_cmp++; if (bus.Dataout !== 8'h3C) begin n_bad++; $display("FAIL glitch_dataout got %h want 3c", bus.Dataout); end
  endtask

  task automatic test_break();
    vq.delete();
    send_frame(8'h81, 1'b0, 1'b0);
    tick(24);
    n_cmp++; if (bus.Busy !== 1'b1) begin n_bad++; $display("FAIL brk_busy got %b want 1", bus.Busy); end
    n_cmp++;
    if (vq.size() !== 1) begin n_bad++; $display("FAIL brk_count got %0d want 1", vq.size()); end
    else begin
      n_cmp++;
      if (vq[0] !== 10'h281) begin n_bad++; $display("FAIL brk_frame got %h want 281", vq[0]); end
    end
    bus.Serial_ip = 1'b1;
    tick(40);
    n_cmp++; if (vq.size() !== 1) begin n_bad++; $display("FAIL brk_recover_count got %0d want 1", vq.size()); end
    n_cmp++; if (bus.Busy !== 1'b0) begin n_bad++; $display("FAIL brk_idle got %b want 0", bus.Busy); end
    vq.delete();
    send_frame(8'h5A, 1'b0, 1'b1);
    tick(4);
    n_cmp++;
    if (vq.size() !== 1) begin n_bad++; $display("FAIL brk_next_count got %0d want 1", vq.size()); end
    else begin
      n_cmp++;
      if (vq[0] !== 10'h05A) begin n_bad++; $display("FAIL brk_next_frame got %h want 05a", vq[0]); end
    end
  endtask

  task automatic test_reset_mid();
    vq.delete();
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    drive_bit(1'b1);
    tick(5);
    Rst = 1'b1;
    tick(1);
    n_cmp++; if (bus.Busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy got %b want 0", bus.Busy); end
    n_cmp++; if (bus.Dataout !== 8'h00) begin n_bad++; $display("FAIL rmid_dataout got %h want 00", bus.Dataout); end
    Rst = 1'b0;
    bus.Serial_ip = 1'b1;
    tick(20);
    send_frame(8'h12, 1'b0, 1'b1);
    tick(4);
    n_cmp++;
    if (vq.size() !== 1) begin n_bad++; $display("FAIL rmid_count got %0d want 1", vq.size()); end
    else begin
      n_cmp++;
      if (vq[0] !== 10'h012) begin n_bad++; $display("FAIL rmid_frame got %h want 012", vq[0]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] exp_v [3];
    exp_v[0] = 10'h000;
    exp_v[1] = 10'h0FF;
    exp_v[2] = 10'h055;
    vq.delete();
    send_frame(8'h00, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    send_frame(8'h55, 1'b0, 1'b1);
    tick(4);
    n_cmp++;
    if (vq.size() !== 3) begin n_bad++; $display("FAIL b2b_count got %0d want 3", vq.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (vq[i] !== exp_v[i]) begin n_bad++; $display("FAIL b2b_frame%0d got %h want %h", i, vq[i], exp_v[i]); end
      end
    end
  endtask

  task automatic test_loopback();
    logic [7:0] sent[$];
    logic [7:0] b;
    vq.delete();
    for (int i = 0; i < 256; i++) begin
      b = 8'($urandom_range(0, 255));
      sent.push_back(b);
      send_frame(b, 1'b0, 1'b1);
    end
    tick(4);
    n_cmp++;
    if (vq.size() !== 256) begin n_bad++; $display("FAIL loop_count got %0d want 256", vq.size()); end
    else begin
      for (int i = 0; i < 256; i++) begin
        n_cmp++;
        if (vq[i] !== {2'b00, sent[i]}) begin
          n_bad++; $display("FAIL loop_byte%0d got %h want %h", i, vq[i], {2'b00, sent[i]});
        end
      end
    end
  endtask

  initial begin
    bus.Serial_ip = 1'b1;
    test_reset();
    test_good_frame();
    test_parity_err();
    test_glitch();
    test_break();
    test_reset_mid();
    test_back_to_back();
    test_loopback();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
